// File: rtl/ram_port_arbiter_if.sv
// Signal bundle tying two HLS kernels and a shared 1R/1W RAM to the arbiter.
// master = kernels + RAM side, slave = arbiter side.
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  req_0;
    logic                  req_1;
    logic                  req_we_0;
    logic                  req_we_1;
    logic [ADDR_WIDTH-1:0] req_addr_0;
    logic [ADDR_WIDTH-1:0] req_addr_1;
    logic [DATA_WIDTH-1:0] req_wdata_0;
    logic [DATA_WIDTH-1:0] req_wdata_1;
    logic                  gnt_0;
    logic                  gnt_1;
    logic                  rvalid_0;
    logic                  rvalid_1;
    logic [DATA_WIDTH-1:0] rdata_0;
    logic [DATA_WIDTH-1:0] rdata_1;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (
        output req_0, req_1, req_we_0, req_we_1, req_addr_0, req_addr_1,
               req_wdata_0, req_wdata_1, rdata,
        input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
               raddr, wen, waddr, wdata
    );

    modport slave (
        input  req_0, req_1, req_we_0, req_we_1, req_addr_0, req_addr_1,
               req_wdata_0, req_wdata_1, rdata,
        output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
               raddr, wen, waddr, wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a 1R/1W RAM: independent round-robin per port,
// same-address write-over-read priority, and stall-safe read return capture.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              global_stall,
    ram_port_arbiter_if.slave bus
);
    logic [1:0]            w_req;
    logic [1:0]            w_we;
    logic [1:0]            w_rd_cand;
    logic [1:0]            w_wr_cand;
    logic [1:0]            w_gnt;
    logic [ADDR_WIDTH-1:0] w_addr  [2];
    logic [DATA_WIDTH-1:0] w_wdata [2];
    logic                  w_active;
    logic                  w_rd_win;
    logic                  w_wr_win;
    logic                  w_rd_any;
    logic                  w_wr_gnt;
    logic                  w_rd_gnt;
    logic                  w_hazard;

    logic                  r_rd_prio;
    logic                  r_wr_prio;
    logic                  r_rd_pending;
    logic                  r_rd_owner;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [1:0]            r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata [2];

    assign w_req      = {bus.req_1, bus.req_0};
    assign w_we       = {bus.req_we_1, bus.req_we_0};
    assign w_addr[0]  = bus.req_addr_0;
    assign w_addr[1]  = bus.req_addr_1;
    assign w_wdata[0] = bus.req_wdata_0;
    assign w_wdata[1] = bus.req_wdata_1;

    assign w_active  = !rst && !global_stall;
    // A requester still holding an undelivered, stalled result may not read again.
    assign w_rd_cand = w_req & ~w_we & ~(r_rvalid & {2{global_stall}});
    assign w_wr_cand = w_req & w_we;

    function automatic logic rr_pick(input logic [1:0] cand, input logic prio);
        return (cand == 2'b11) ? prio : cand[1];
    endfunction

    always_comb begin
        // NOTE: w_gnt gets a default before the conditional sets, so no latch is inferred.
        w_gnt    = '0;
        w_rd_win = rr_pick(w_rd_cand, r_rd_prio);
        w_wr_win = rr_pick(w_wr_cand, r_wr_prio);
        w_wr_gnt = w_active && (w_wr_cand != 2'b00);
        w_rd_any = w_active && (w_rd_cand != 2'b00);
        w_hazard = w_wr_gnt && w_rd_any && (w_addr[w_rd_win] == w_addr[w_wr_win]);
        w_rd_gnt = w_rd_any && !w_hazard;
        if (w_rd_gnt) w_gnt[w_rd_win] = 1'b1;
        if (w_wr_gnt) w_gnt[w_wr_win] = 1'b1;
    end

    assign bus.gnt_0    = w_gnt[0];
    assign bus.gnt_1    = w_gnt[1];
    assign bus.wen      = w_wr_gnt;
    assign bus.waddr    = w_wr_gnt ? w_addr[w_wr_win]  : '0;
    assign bus.wdata    = w_wr_gnt ? w_wdata[w_wr_win] : '0;
    assign bus.raddr    = w_rd_gnt ? w_addr[w_rd_win]  : r_raddr;
    assign bus.rvalid_0 = r_rvalid[0];
    assign bus.rvalid_1 = r_rvalid[1];
    assign bus.rdata_0  = r_rdata[0];
    assign bus.rdata_1  = r_rdata[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the return registers are plain flops and are reset; the RAM array itself is not.
            r_rd_prio    <= 1'b0;
            r_wr_prio    <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= 1'b0;
            r_raddr      <= '0;
            r_rvalid     <= '0;
            r_rdata[0]   <= '0;
            r_rdata[1]   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_rd_pending <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_prio  <= !w_rd_win;
                r_rd_owner <= w_rd_win;
                r_raddr    <= w_addr[w_rd_win];
            end
            if (w_wr_gnt) r_wr_prio <= !w_wr_win;
            // Capture proceeds even while stalled; delivery only retires on a free cycle.
            for (int i = 0; i < 2; i++) begin
                if (r_rd_pending && (int'(r_rd_owner) == i)) begin
                    r_rvalid[i] <= 1'b1;
                    r_rdata[i]  <= bus.rdata;
                end else if (!global_stall) begin
                    r_rvalid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_ram_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic global_stall = 1'b0;

    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .global_stall (global_stall),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Shared RAM with registered read.
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (bus.wen) ram[bus.waddr] <= bus.wdata;
        bus.rdata <= ram[bus.raddr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input bit en, input bit we, input int addr, input int data);
        if (i == 0) begin
            bus.req_0 = en; bus.req_we_0 = we;
            bus.req_addr_0 = AW'(addr); bus.req_wdata_0 = DW'(data);
        end else begin
            bus.req_1 = en; bus.req_we_1 = we;
            bus.req_addr_1 = AW'(addr); bus.req_wdata_1 = DW'(data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [1:0] c, input bit p);
        if (c == 2'b11) return p ? 1 : 0;
        for (int i = 0; i < 2; i++) if (c[i]) return i;
        return -1;
    endfunction

    // Reference model: memory contents, one outstanding read, per-requester delivery.
    logic [DW-1:0] m_mem [32];
    bit            m_rd_prio, m_wr_prio;
    bit            m_pend;
    int            m_pend_own;
    logic [DW-1:0] m_pend_data;
    bit            m_vld [2];
    logic [DW-1:0] m_dat [2];
    logic [AW-1:0] m_raddr;

    always @(negedge clk) begin : model
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic [1:0]    rc, wc, eg;
        logic [AW-1:0] e_waddr, e_raddr;
        logic [DW-1:0] e_wdata;
        int            rw, ww;
        bit            rg, wg;
        a[0] = bus.req_addr_0;  a[1] = bus.req_addr_1;
        d[0] = bus.req_wdata_0; d[1] = bus.req_wdata_1;
        if (rst) begin
            check("rst_gnt",    {bus.gnt_1, bus.gnt_0}, 2'b00);
            check("rst_wen",    bus.wen, 1'b0);
            check("rst_waddr",  bus.waddr, 0);
            check("rst_wdata",  bus.wdata, 0);
            check("rst_raddr",  bus.raddr, 0);
            check("rst_rvalid", {bus.rvalid_1, bus.rvalid_0}, 2'b00);
            check("rst_rdata0", bus.rdata_0, 0);
            check("rst_rdata1", bus.rdata_1, 0);
            m_rd_prio = 0; m_wr_prio = 0; m_pend = 0; m_pend_own = 0;
            m_vld[0] = 0; m_vld[1] = 0; m_dat[0] = '0; m_dat[1] = '0; m_raddr = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic r, w;
                r = (i == 0) ? bus.req_0 : bus.req_1;
                w = (i == 0) ? bus.req_we_0 : bus.req_we_1;
                rc[i] = r && !w && !(m_vld[i] && global_stall);
                wc[i] = r && w;
            end
            rw = pick(rc, m_rd_prio);
            ww = pick(wc, m_wr_prio);
            wg = !global_stall && (ww >= 0);
            rg = !global_stall && (rw >= 0);
            if (rg && wg && (a[rw] == a[ww])) rg = 0;
            eg = 2'b00;
            if (rg) eg[rw] = 1'b1;
            if (wg) eg[ww] = 1'b1;
            e_waddr = wg ? a[ww] : '0;
            e_wdata = wg ? d[ww] : '0;
            e_raddr = rg ? a[rw] : m_raddr;
            check("gnt",    {bus.gnt_1, bus.gnt_0}, eg);
            check("wen",    bus.wen, wg);
            check("waddr",  bus.waddr, e_waddr);
            check("wdata",  bus.wdata, e_wdata);
            check("raddr",  bus.raddr, e_raddr);
            check("rvalid", {bus.rvalid_1, bus.rvalid_0}, {m_vld[1], m_vld[0]});
            check("rdata0", bus.rdata_0, m_dat[0]);
            check("rdata1", bus.rdata_1, m_dat[1]);
            for (int i = 0; i < 2; i++) begin
                if (m_pend && m_pend_own == i) begin
                    m_vld[i] = 1;
                    m_dat[i] = m_pend_data;
                end else if (!global_stall) begin
                    m_vld[i] = 0;
                end
            end
            m_pend = rg;
            if (rg) begin
                m_pend_own  = rw;
                m_pend_data = m_mem[a[rw]];
                m_raddr     = a[rw];
                m_rd_prio   = (rw == 0);
            end
            if (wg) begin
                m_mem[a[ww]] = d[ww];
                m_wr_prio    = (ww == 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i] = '0;
            m_mem[i] = '0;
        end
        ram[2] = 5;  m_mem[2] = 5;
        ram[3] = 7;  m_mem[3] = 7;
        bus.rdata = '0;
        set_req(0, 1, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);

        // Reset with a request pending.
        tick();
        #2;
        check("reset_gnt0",   bus.gnt_0, 0);
        check("reset_wen",    bus.wen, 0);
        check("reset_rvalid0", bus.rvalid_0, 0);
        check("reset_rdata0", bus.rdata_0, 0);
        check("reset_raddr",  bus.raddr, 0);

        tick();
        rst = 1'b0;
        set_req(0, 1, 1, 1, 10);
        #2;
        check("first_wr_gnt0", bus.gnt_0, 1);
        check("first_wr_wen",  bus.wen, 1);
        check("first_wr_waddr", bus.waddr, 1);
        check("first_wr_wdata", bus.wdata, 10);

        // Round-robin between two readers.
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) begin
                set_req(0, 1, 0, 2, 0);
                set_req(1, 1, 0, 3, 0);
            end else begin
                set_req(0, 0, 0, 0, 0);
                set_req(1, 0, 0, 0, 0);
            end
            #2;
            if (k < 4) begin
                check("rr_gnt0", bus.gnt_0, (k % 2 == 0));
                check("rr_gnt1", bus.gnt_1, (k % 2 == 1));
            end
            if (k >= 2 && k % 2 == 0) begin
                check("rr_rvalid0", bus.rvalid_0, 1);
                check("rr_rdata0",  bus.rdata_0, 5);
            end
            if (k >= 2 && k % 2 == 1) begin
                check("rr_rvalid1", bus.rvalid_1, 1);
                check("rr_rdata1",  bus.rdata_1, 7);
            end
        end

        // Write and read from different requesters in the same cycle.
        tick();
        set_req(0, 1, 1, 4, 9);
        set_req(1, 1, 0, 1, 0);
        #2;
        check("dual_gnt0", bus.gnt_0, 1);
        check("dual_gnt1", bus.gnt_1, 1);
        tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        tick();
        #2;
        check("dual_rvalid1", bus.rvalid_1, 1);
        check("dual_rdata1",  bus.rdata_1, 10);

        // Same-address hazard: write wins, read retries and sees new data.
        tick();
        set_req(0, 1, 1, 6, 20);
        set_req(1, 1, 0, 6, 0);
        #2;
        check("hazard_gnt0", bus.gnt_0, 1);
        check("hazard_gnt1", bus.gnt_1, 0);
        tick();
        set_req(0, 0, 0, 0, 0);
        #2;
        check("hazard_retry_gnt1", bus.gnt_1, 1);
        tick();
        set_req(1, 0, 0, 0, 0);
        tick();
        #2;
        check("hazard_rvalid1", bus.rvalid_1, 1);
        check("hazard_rdata1",  bus.rdata_1, 20);

        // Stall right after a read grant.
        tick();
        set_req(0, 1, 0, 4, 0);
        #2;
        check("stall_gnt0", bus.gnt_0, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            global_stall = 1'b1;
            set_req(0, 0, 0, 0, 0);
            set_req(1, 1, 1, 7, 33);
            #2;
            check("stall_gnt", {bus.gnt_1, bus.gnt_0}, 2'b00);
            check("stall_wen", bus.wen, 0);
            if (k >= 2) begin
                check("stall_rvalid0", bus.rvalid_0, 1);
                check("stall_rdata0",  bus.rdata_0, 9);
            end
        end
        tick();
        global_stall = 1'b0;
        set_req(1, 0, 0, 0, 0);
        #2;
        check("stall_release_rvalid0", bus.rvalid_0, 1);
        check("stall_release_rdata0",  bus.rdata_0, 9);
        tick();
        #2;
        check("stall_clear_rvalid0", bus.rvalid_0, 0);

        // Reset in the cycle after a read grant.
        tick();
        set_req(0, 1, 1, 9, 1);
        tick();
        set_req(0, 1, 0, 2, 0);
        #2;
        check("midrst_gnt0", bus.gnt_0, 1);
        tick();
        set_req(0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        check("midrst_rvalid_a", {bus.rvalid_1, bus.rvalid_0}, 2'b00);
        tick();
        rst = 1'b0;
        set_req(0, 1, 0, 2, 0);
        set_req(1, 1, 0, 3, 0);
        #2;
        check("midrst_rd_prio_gnt0", bus.gnt_0, 1);
        check("midrst_rd_prio_gnt1", bus.gnt_1, 0);
        check("midrst_rvalid_b", {bus.rvalid_1, bus.rvalid_0}, 2'b00);
        tick();
        set_req(0, 1, 1, 10, 1);
        set_req(1, 1, 1, 11, 2);
        #2;
        check("midrst_wr_prio_gnt0", bus.gnt_0, 1);
        check("midrst_wr_prio_gnt1", bus.gnt_1, 0);
        check("midrst_rvalid_c", {bus.rvalid_1, bus.rvalid_0}, 2'b00);

        // Randomized traffic; small address range to provoke hazards.
        for (int k = 0; k < 3000; k++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            global_stall = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 2; i++)
                set_req(i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 7), int'($urandom));
        end
        tick();
        rst = 1'b0;
        global_stall = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
